// File: rtl/cc_counter_pkg.sv
// Shared definitions for the cc_* counter family: FSM state encoding, default width
// and the per-bit J/K steering operation used by the down-counter.
package cc_counter_pkg;

  localparam logic [1:0] CC_IDLE  = 2'b00;
  localparam logic [1:0] CC_RUN   = 2'b01;
  localparam logic [1:0] CC_DONE  = 2'b10;
  localparam int         CC_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = CC_IDLE,
    ST_RUN     = CC_RUN,
    ST_DONE    = CC_DONE,
    ST_ILLEGAL = 2'b11
  } cc_state_e;

  // What every count bit's J/K inputs do this cycle.
  typedef enum logic [1:0] {
    BIT_HOLD = 2'b00,
    BIT_LOAD = 2'b01,
    BIT_DEC  = 2'b10
  } cc_bit_op_e;

endpackage

// File: rtl/jk_ff_n.sv
// Single JK flip-flop: posedge clock, asynchronous active-low reset to 0.
// Truth table {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff_n (
  input  logic j,
  input  logic k,
  input  logic clock,
  input  logic reset_n,
  output logic y,
  output logic y_bar
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   y <= 1'b0;
        2'b10:   y <= 1'b1;
        2'b11:   y <= ~y;
        default: y <= y;
      endcase
    end
  end

  assign y_bar = ~y;

endmodule

// File: rtl/cc_down_counter.sv
// Loadable WIDTH-bit down-counter / countdown timer built from JK flops, with a
// small IDLE/RUN/DONE control FSM and optional auto-reload at terminal count.
module cc_down_counter
  import cc_counter_pkg::*;
#(
  parameter int WIDTH       = CC_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clock_counter,
  input  logic             reset_counter,
  input  logic             start,
  input  logic             abort,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  cc_state_e        state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, done_q, done_d;
  cc_bit_op_e       op;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] y_bar;

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    op        = BIT_HOLD;
    load_data = load_value;
    if (start) begin
      op       = BIT_LOAD;
      reload_d = load_value;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (enable) begin
            if (zero) begin
              done_d = 1'b1;
              if (AUTO_RELOAD) begin
                op        = BIT_LOAD;
                load_data = reload_q;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              op = BIT_DEC;
            end
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: the reload register is a plain flop bank and is cleared by reset like any other state.
  always_ff @(posedge clock_counter or negedge reset_counter) begin
    if (!reset_counter) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == ST_RUN);
      done_q   <= done_d;
    end
  end

  // Bit i toggles on a decrement only when all lower bits are 0 (borrow ripples up).
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic borrow;
    logic j, k;

    if (i == 0) begin : g_lsb
      assign borrow = 1'b1;
    end else begin : g_upper
      assign borrow = ~|y[i-1:0];
    end

    always_comb begin
      j = 1'b0;
      k = 1'b0;
      case (op)
        BIT_LOAD: begin
          j = load_data[i];
          k = ~load_data[i];
        end
        BIT_DEC: begin
          j = borrow;
          k = borrow;
        end
        default: ;
      endcase
    end

    jk_ff_n u_ff (
      .j      (j),
      .k      (k),
      .clock  (clock_counter),
      .reset_n(reset_counter),
      .y      (y[i]),
      .y_bar  (y_bar[i])
    );
  end

  assign zero = &y_bar;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cc_down_counter.sv
// Bench for cc_down_counter: a non-reload and an auto-reload instance share stimulus;
// a behavioural model pushes expectations per cycle and a monitor pops and compares.
module tb_cc_down_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, enable;
  logic [3:0] load_value;
  logic [3:0] y0, y1;
  logic       z0, z1, b0, b1, d0, d1;

  always #5 clk = ~clk;

  cc_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clock_counter(clk), .reset_counter(rst_n), .start(start), .abort(abort),
    .enable(enable), .load_value(load_value), .y(y0), .zero(z0), .busy(b0), .done(d0)
  );

  cc_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clock_counter(clk), .reset_counter(rst_n), .start(start), .abort(abort),
    .enable(enable), .load_value(load_value), .y(y1), .zero(z1), .busy(b1), .done(d1)
  );

  typedef struct packed {
    logic [3:0] y;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  int   checks   = 0;
  int   failures = 0;
  int   dc0      = 0;
  int   dc1      = 0;

  // Reference model state: index 0 = non-reload, 1 = auto-reload. st: 0 idle, 1 run, 2 done.
  logic [3:0] m_y[2];
  logic [3:0] m_rl[2];
  int         m_st[2];
  logic       m_done[2];

  function void model_reset();
    for (int a = 0; a < 2; a++) begin
      m_y[a] = 4'd0; m_rl[a] = 4'd0; m_st[a] = 0; m_done[a] = 1'b0;
    end
  endfunction

  function void model_step(input int a, input logic st, input logic ab, input logic en,
                           input logic [3:0] lv);
    m_done[a] = 1'b0;
    if (st) begin
      m_y[a] = lv; m_rl[a] = lv; m_st[a] = 1;
    end else if (m_st[a] == 1) begin
      if (ab) m_st[a] = 0;
      else if (en) begin
        if (m_y[a] != 4'd0) m_y[a] = m_y[a] - 4'd1;
        else begin
          m_done[a] = 1'b1;
          if (a == 1) m_y[a] = m_rl[a];
          else m_st[a] = 2;
        end
      end
    end
  endfunction

  // Drive one cycle of inputs at the falling edge, record expectations, wait past the
  // following rising edge (and past the monitor's compare).
  task automatic drive(input logic st, input logic ab, input logic en, input logic [3:0] lv);
    @(negedge clk);
    start = st; abort = ab; enable = en; load_value = lv;
    model_step(0, st, ab, en, lv);
    model_step(1, st, ab, en, lv);
    sb0.push_back('{y: m_y[0], busy: (m_st[0] == 1), done: m_done[0]});
    sb1.push_back('{y: m_y[1], busy: (m_st[1] == 1), done: m_done[1]});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && sb0.size() > 0 && sb1.size() > 0) begin
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      checks += 8;
      if (y0 !== e0.y)    begin failures++; $display("FAIL sb_y0 t=%0t got=%0h exp=%0h", $time, y0, e0.y); end
      if (b0 !== e0.busy) begin failures++; $display("FAIL sb_busy0 t=%0t got=%0b exp=%0b", $time, b0, e0.busy); end
      if (d0 !== e0.done) begin failures++; $display("FAIL sb_done0 t=%0t got=%0b exp=%0b", $time, d0, e0.done); end
      if (z0 !== (e0.y == 4'd0)) begin failures++; $display("FAIL sb_zero0 t=%0t got=%0b exp=%0b", $time, z0, (e0.y == 4'd0)); end
      if (y1 !== e1.y)    begin failures++; $display("FAIL sb_y1 t=%0t got=%0h exp=%0h", $time, y1, e1.y); end
      if (b1 !== e1.busy) begin failures++; $display("FAIL sb_busy1 t=%0t got=%0b exp=%0b", $time, b1, e1.busy); end
      if (d1 !== e1.done) begin failures++; $display("FAIL sb_done1 t=%0t got=%0b exp=%0b", $time, d1, e1.done); end
      if (z1 !== (e1.y == 4'd0)) begin failures++; $display("FAIL sb_zero1 t=%0t got=%0b exp=%0b", $time, z1, (e1.y == 4'd0)); end
      dc0 += int'(d0);
      dc1 += int'(d1);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; enable = 1'b0; load_value = 4'd0;
    model_reset();
    #1;
    checks++;
    if ({y0, b0, d0, z0} !== 7'b0000_001) begin
      failures++; $display("FAIL reset_state got=%b exp=%b", {y0, b0, d0, z0}, 7'b0000_001);
    end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd9);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 4'd0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks += 2;
    if ({y0, b0, d0, z0} !== 7'b0000_001) begin
      failures++; $display("FAIL reset_midcount0 got=%b exp=%b", {y0, b0, d0, z0}, 7'b0000_001);
    end
    if ({y1, b1, d1, z1} !== 7'b0000_001) begin
      failures++; $display("FAIL reset_midcount1 got=%b exp=%b", {y1, b1, d1, z1}, 7'b0000_001);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_countdown();
    int base;
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    checks++;
    if (y0 !== 4'd3) begin failures++; $display("FAIL cd_load got=%0d exp=3", y0); end
    base = dc0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      checks++;
      if (y0 !== 4'(3 - i)) begin failures++; $display("FAIL cd_step%0d got=%0d exp=%0d", i, y0, 3 - i); end
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (d0 !== 1'b1 || b0 !== 1'b0) begin
      failures++; $display("FAIL cd_terminal done=%0b busy=%0b exp done=1 busy=0", d0, b0);
    end
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    repeat (9) drive(1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (dc0 - base != 1 || y0 !== 4'd0 || b0 !== 1'b0) begin
      failures++; $display("FAIL cd_hold pulses=%0d y=%0d busy=%0b exp 1,0,0", dc0 - base, y0, b0);
    end
  endtask

  task automatic test_auto_reload();
    int base;
    logic [3:0] exp_y;
    drive(1'b1, 1'b0, 1'b0, 4'd2);
    base = dc1;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      exp_y = (k % 3 == 0) ? 4'd2 : 4'(2 - (k % 3));
      checks++;
      if (y1 !== exp_y) begin failures++; $display("FAIL ar_step%0d got=%0d exp=%0d", k, y1, exp_y); end
    end
    checks++;
    if (dc1 - base != 4) begin failures++; $display("FAIL ar_pulses got=%0d exp=4", dc1 - base); end
  endtask

  task automatic test_enable_gaps();
    drive(1'b1, 1'b0, 1'b0, 4'd5);
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (y0 !== 4'd3) begin failures++; $display("FAIL gap_count got=%0d exp=3", y0); end
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (y0 !== 4'd3 || b0 !== 1'b0) begin
      failures++; $display("FAIL gap_abort y=%0d busy=%0b exp y=3 busy=0", y0, b0);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd7);
    checks++;
    if (y0 !== 4'd7 || b0 !== 1'b1) begin
      failures++; $display("FAIL gap_start_wins y=%0d busy=%0b exp y=7 busy=1", y0, b0);
    end
  endtask

  task automatic test_boundaries();
    int wraps = 0;
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (d0 !== 1'b1 || d1 !== 1'b1 || b1 !== 1'b1) begin
      failures++; $display("FAIL bd_zero_load d0=%0b d1=%0b b1=%0b exp 1,1,1", d0, d1, b1);
    end
    drive(1'b1, 1'b0, 1'b0, 4'hF);
    repeat (15) drive(1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (y0 !== 4'd0 || d0 !== 1'b0) begin
      failures++; $display("FAIL bd_full_range y=%0h done=%0b exp y=0 done=0", y0, d0);
    end
    repeat (4) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      if (y0 == 4'hF) wraps++;
    end
    checks++;
    if (wraps != 0 || y0 !== 4'd0) begin
      failures++; $display("FAIL bd_no_wrap wraps=%0d y=%0h exp 0,0", wraps, y0);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_auto_reload();
    test_enable_gaps();
    test_boundaries();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      failures++; $display("FAIL sb_drain left=%0d/%0d exp=0", sb0.size(), sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
